comporta_sequenciador: RTL
==========================

Name: comporta_sequenciador

Overview:
- Controller for the gate (comporta) servo datapath.
- Arbitrates open requests from three sources: manual button, weight-in-interval detector, serial command.
- Sequences the servo position index step by step up to fully open, holds, then steps back to closed.
- Drives the 3-bit position select that feeds the PWM position mux; reports state on a 4-bit debug code for the hex displays.

Parameters:
N_POS, 8, number of servo positions (0 = closed, N_POS-1 = fully open); 2..8
PASSO, 50000, clock cycles spent at each position while opening or closing
ABERTO, 5000000, clock cycles the gate holds fully open before closing

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
req_manual  input  1  manual open request, level, already debounced
req_auto  input  1  weight-within-interval request, level
req_serial  input  1  serial open command, one-cycle pulse
peso_max_zero  input  1  max weight register is zero; inhibits and aborts opening
posicao  output  3  current servo position index
aberta  output  1  gate fully open
ocupado  output  1  sequence in progress
grant  output  2  active source: 00 none, 01 manual, 10 serial, 11 auto
fim  output  1  one-cycle pulse when the sequence finishes at position 0
db_estado  output  4  state code for display

Behaviour:
- Reset (reset=0, async): state OCIOSO, posicao=0, timer=0, serial pending flag=0, all outputs 0.
- Serial latch:
  - req_serial=1 sets a sticky pending flag; repeated pulses while set have no extra effect.
  - The flag clears when serial is granted.
  - A pulse in the same cycle as that grant leaves the flag set (new pulse wins).
- Fixed priority: manual > serial(pending) > auto. The grant is sampled once per sequence.
- States and db_estado codes: OCIOSO=0, ABRINDO=2, ABERTA=3, FECHANDO=4, FIM=5.
- OCIOSO:
  - Requests are evaluated only here.
  - If any request is present and peso_max_zero=0: load grant, timer=0, go to ABRINDO next cycle.
  - If peso_max_zero=1: stay; serial pending is preserved.
- ABRINDO:
  - timer increments each cycle.
  - At timer==PASSO-1: timer<=0, posicao<=posicao+1.
  - If posicao==N_POS-2 at that edge, go to ABERTA.
- ABERTA:
  - timer increments.
  - If the granted source is manual or auto and still asserted, timer<=0 (hold extended). A serial grant is never extended.
  - At timer==ABERTO-1 with no extension: timer<=0, go to FECHANDO.
- FECHANDO:
  - At timer==PASSO-1: timer<=0, posicao<=posicao-1.
  - If posicao==1 at that edge, go to FIM.
  - Requests are ignored here, except that a serial pulse still sets the pending flag.
- FIM: fim=1 for this single cycle, grant<=00, go to OCIOSO.
- Abort: peso_max_zero=1 in ABRINDO or ABERTA → FECHANDO next cycle, timer<=0, descend from the current posicao.
- Abort edge cases:
  - If posicao==0 at abort, FECHANDO goes to FIM at its first timer==PASSO-1 without decrementing.
  - This same rule applies whenever FECHANDO is entered with posicao==0.
- Output decode:
  - aberta=1 only in ABERTA.
  - ocupado=1 in ABRINDO, ABERTA and FECHANDO.
  - grant holds its value from ABRINDO through FECHANDO.
- Latency: request seen in OCIOSO at cycle t → ABRINDO and ocupado=1 at t+1; posicao=1 at t+1+PASSO.
- Timer width: ceil(log2(max(PASSO,ABERTO))). posicao never wraps; it stays within 0..N_POS-1.

Test Plan:
(All scenarios: N_POS=4, PASSO=3, ABERTO=5.)
- Manual 1-cycle pulse at t0:
  - ABRINDO and grant=01 at t0+1.
  - posicao=1,2,3 at t0+4, t0+7, t0+10; aberta=1 from t0+10.
  - FECHANDO at t0+15; posicao=2,1 at t0+18, t0+21.
  - posicao=0 with FIM and fim=1 at t0+24; OCIOSO at t0+25.
- Manual, auto and serial all asserted at t0:
  - grant=01 and serial pending stays set.
  - After OCIOSO at t0+25, grant=10 and ABRINDO at t0+26, pending cleared (auto still high but lower priority).
- req_auto held high through ABERTA: aberta stays 1 indefinitely. Drop auto at cycle tx → FECHANDO at tx+5.
- peso_max_zero=1 while posicao=2 in ABRINDO → FECHANDO next cycle, timer=0; posicao=1 three cycles later, 0 three cycles after that, with fim=1.
- peso_max_zero=1 in OCIOSO with a serial pulse → no sequence starts. Release peso_max_zero → grant=10, ABRINDO next cycle.
- reset=0 asserted mid-ABERTA → immediately posicao=0, aberta=0, ocupado=0, grant=00, db_estado=0, pending cleared.

Source files
------------

// File: rtl/comporta_sequenciador.sv
// Gate (comporta) servo sequencer.
// Arbitrates open requests from the manual, serial and auto sources.
// Steps the servo position up to fully open, holds there, then steps back down to closed.
// Reports the current state on a 4-bit code for the hex displays.
module comporta_sequenciador #(
    parameter int N_POS  = 8,        // servo positions, 0 = closed, N_POS-1 = fully open
    parameter int PASSO  = 50000,    // cycles spent at each intermediate position
    parameter int ABERTO = 5000000   // cycles held fully open before closing
) (
    input  logic       clock,
    input  logic       reset,          // asynchronous, active-low
    input  logic       req_manual,
    input  logic       req_auto,
    input  logic       req_serial,
    input  logic       peso_max_zero,
    output logic [2:0] posicao,
    output logic       aberta,
    output logic       ocupado,
    output logic [1:0] grant,
    output logic       fim,
    output logic [3:0] db_estado
);

    // One shared timer serves both the per-step delay and the open hold,
    // so it is sized for the longer of the two.
    localparam int T_MAX = (PASSO > ABERTO) ? PASSO : ABERTO;
    localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;

    localparam logic [TW-1:0] T_ZERO     = '0;
    localparam logic [TW-1:0] T_UM       = TW'(1);
    localparam logic [TW-1:0] PASSO_FIM  = TW'(PASSO - 1);
    localparam logic [TW-1:0] ABERTO_FIM = TW'(ABERTO - 1);
    localparam logic [2:0]    POS_TOPO   = 3'(N_POS - 2);   // last step before fully open

    localparam logic [1:0] G_NENHUM = 2'b00;
    localparam logic [1:0] G_MANUAL = 2'b01;
    localparam logic [1:0] G_SERIAL = 2'b10;
    localparam logic [1:0] G_AUTO   = 2'b11;

    // Encodings double as the display code.
    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        ABRINDO  = 4'd2,
        ABERTA   = 4'd3,
        FECHANDO = 4'd4,
        FIM      = 4'd5
    } estado_t;

    estado_t       r_estado, w_estado_next;
    logic [TW-1:0] r_timer,  w_timer_next;
    logic [2:0]    r_posicao, w_posicao_next;
    logic [1:0]    r_grant,  w_grant_next;
    logic          r_pend,   w_pend_next;
    logic          w_pend_clr;
    logic          w_tem_req;
    logic [1:0]    w_sel;
    logic          w_estende;

    // Fixed priority selection: manual over pending serial over auto.
    always_comb begin
        w_sel = G_NENHUM;
        if (req_manual)
            w_sel = G_MANUAL;
        else if (r_pend)
            w_sel = G_SERIAL;
        else if (req_auto)
            w_sel = G_AUTO;
    end

    assign w_tem_req = req_manual | r_pend | req_auto;

    // A level source that still holds its request keeps the gate open; a serial grant never does.
    assign w_estende = ((r_grant == G_MANUAL) && req_manual) ||
                       ((r_grant == G_AUTO)   && req_auto);

    // Next-state, timer, position and grant computation.
    always_comb begin
        w_estado_next  = r_estado;
        w_timer_next   = r_timer;
        w_posicao_next = r_posicao;
        w_grant_next   = r_grant;
        w_pend_clr     = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (w_tem_req && !peso_max_zero) begin
                    w_grant_next  = w_sel;
                    w_timer_next  = T_ZERO;
                    w_estado_next = ABRINDO;
                    w_pend_clr    = (w_sel == G_SERIAL);
                end
            end
            ABRINDO: begin
                if (peso_max_zero) begin
                    // Abort: descend from wherever the servo currently is.
                    w_timer_next  = T_ZERO;
                    w_estado_next = FECHANDO;
                end else if (r_timer == PASSO_FIM) begin
                    w_timer_next   = T_ZERO;
                    w_posicao_next = r_posicao + 3'd1;
                    if (r_posicao == POS_TOPO)
                        w_estado_next = ABERTA;
                end else begin
                    w_timer_next = r_timer + T_UM;
                end
            end
            ABERTA: begin
                if (peso_max_zero) begin
                    w_timer_next  = T_ZERO;
                    w_estado_next = FECHANDO;
                end else if (w_estende) begin
                    w_timer_next = T_ZERO;
                end else if (r_timer == ABERTO_FIM) begin
                    w_timer_next  = T_ZERO;
                    w_estado_next = FECHANDO;
                end else begin
                    w_timer_next = r_timer + T_UM;
                end
            end
            FECHANDO: begin
                if (r_timer == PASSO_FIM) begin
                    w_timer_next = T_ZERO;
                    if (r_posicao == 3'd0) begin
                        // Entered already closed (abort at position 0): finish without underflow.
                        w_estado_next = FIM;
                    end else begin
                        w_posicao_next = r_posicao - 3'd1;
                        if (r_posicao == 3'd1)
                            w_estado_next = FIM;
                    end
                end else begin
                    w_timer_next = r_timer + T_UM;
                end
            end
            FIM: begin
                w_grant_next  = G_NENHUM;
                w_timer_next  = T_ZERO;
                w_estado_next = OCIOSO;
            end
            default: begin
                w_grant_next  = G_NENHUM;
                w_timer_next  = T_ZERO;
                w_estado_next = OCIOSO;
            end
        endcase
    end

    // Sticky serial flag: a new pulse wins over a clear in the same cycle.
    always_comb begin
        w_pend_next = r_pend;
        if (req_serial)
            w_pend_next = 1'b1;
        else if (w_pend_clr)
            w_pend_next = 1'b0;
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado  <= OCIOSO;
            r_timer   <= T_ZERO;
            r_posicao <= 3'd0;
            r_grant   <= G_NENHUM;
            r_pend    <= 1'b0;
        end else begin
            r_estado  <= w_estado_next;
            r_timer   <= w_timer_next;
            r_posicao <= w_posicao_next;
            r_grant   <= w_grant_next;
            r_pend    <= w_pend_next;
        end
    end

    assign posicao   = r_posicao;
    assign aberta    = (r_estado == ABERTA);
    assign ocupado   = (r_estado == ABRINDO) || (r_estado == ABERTA) || (r_estado == FECHANDO);
    assign grant     = r_grant;
    assign fim       = (r_estado == FIM);
    assign db_estado = r_estado;

endmodule
